// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_elastic
//  Description : Chain of DEPTH elastic register stages carrying a payload,
//                a control field and a valid bit. Provides a valid/ready
//                handshake with bubble collapsing, a synchronous flush that
//                squashes valid and control bits, and a global hold enable.
//                Optional occupancy counter under macro PIPE_STAGE_OCC_CNT_EN;
//                without it the occ port is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int                DATA_W     = 32,
    parameter int                CTRL_W     = 2,
    parameter int                DEPTH      = 1,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int c_occ_w = $clog2(DEPTH + 1);

    // Per-stage state; stage 0 is the input side, stage DEPTH-1 drives outputs
    logic [DEPTH-1:0]  r_v;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CTRL_W-1:0] r_ctrl [DEPTH];

    // Source of each stage: the inputs for stage 0, the previous stage otherwise
    logic [DEPTH-1:0]  w_src_v;
    logic [DATA_W-1:0] w_src_data [DEPTH];
    logic [CTRL_W-1:0] w_src_ctrl [DEPTH];

    // Ready chain; bit DEPTH is the downstream ready
    logic [DEPTH:0]    w_rdy;

    // Chain may advance this cycle (flush wins over everything)
    logic              w_adv;

    assign w_adv = en & ~flush;

    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        if (g == 0) begin : g_head
            assign w_src_v[g]    = in_valid;
            assign w_src_data[g] = in_data;
            assign w_src_ctrl[g] = in_ctrl;
        end else begin : g_link
            assign w_src_v[g]    = r_v[g-1];
            assign w_src_data[g] = r_data[g-1];
            assign w_src_ctrl[g] = r_ctrl[g-1];
        end
    end

    // Ready ripples back from the output: an empty stage is always ready,
    // which is what lets bubbles collapse while the tail is stalled
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = ~r_v[i] | w_rdy[i+1];
        end
    end

    // Stage registers: flush squashes valid/ctrl, otherwise load when ready
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= PRESET_VAL;
                r_ctrl[i] <= '0;
            end
        end else if (flush) begin
            // Payload deliberately keeps its value; only qualifiers are cleared
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_v[i]    <= w_src_v[i];
                    r_ctrl[i] <= w_src_v[i] ? w_src_ctrl[i] : '0;
                    if (w_src_v[i]) begin
                        r_data[i] <= w_src_data[i];
                    end
                end
            end
        end
    end

    assign in_ready  = w_rdy[0] & w_adv;
    assign out_valid = r_v[DEPTH-1] & en;
    // A held or empty tail must never present write-enable style control bits
    assign out_ctrl  = out_valid ? r_ctrl[DEPTH-1] : '0;
    assign out_data  = r_data[DEPTH-1];

`ifdef PIPE_STAGE_OCC_CNT_EN
    localparam logic [c_occ_w-1:0] c_occ_max = c_occ_w'(DEPTH);

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_occ_inc;
    logic               w_occ_dec;
    logic [c_occ_w-1:0] r_occ;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign w_occ_inc  = w_in_xfer & ~w_out_xfer;
    assign w_occ_dec  = w_out_xfer & ~w_in_xfer;

    // Occupancy tracks accepted minus delivered entries, saturating at both ends
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_occ_inc && (r_occ != c_occ_max)) begin
            r_occ <= r_occ + 1'b1;
        end else if (w_occ_dec && (r_occ != '0)) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign occ = r_occ;

    a_occ_no_overflow : assert property (@(posedge clk) disable iff (arst || flush)
        !(w_occ_inc && (r_occ == c_occ_max)));

    a_occ_no_underflow : assert property (@(posedge clk) disable iff (arst || flush)
        !(w_occ_dec && (r_occ == '0)));
`else
    assign occ = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_elastic
//  Description : Scoreboard bench for pipe_stage_elastic (DEPTH=3, 8-bit data,
//                2-bit ctrl). Accepted inputs are queued in order; the monitor
//                pops and compares on every output transfer and checks the
//                handshake against a queue-occupancy reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_elastic;

    localparam int         DEPTH  = 3;
    localparam int         DW     = 8;
    localparam int         CW     = 2;
    localparam logic [7:0] PRESET = 8'h05;

    logic          clk = 1'b0;
    logic          arst;
    logic          en;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occ;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    item_t q[$];
    bit    exp_rdy = 1'b0;
    bit    last_acc;
    int    vectors = 0;
    int    miscompares = 0;

    pipe_stage_elastic #(
        .DATA_W     (DW),
        .CTRL_W     (CW),
        .DEPTH      (DEPTH),
        .PRESET_VAL (PRESET)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: reference handshake from queue occupancy, pop on output transfer
    always @(negedge clk) begin
        int    n;
        item_t it;
        n       = q.size();
        exp_rdy = en && !flush && ((n < DEPTH) || out_ready);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
`ifdef PIPE_STAGE_OCC_CNT_EN
        check("occ", {30'd0, occ}, n);
`else
        check("occ_tied", {30'd0, occ}, 0);
`endif
        if (!en)                 check("out_valid_hold", {31'd0, out_valid}, 0);
        if (n == 0)              check("out_valid_empty", {31'd0, out_valid}, 0);
        if (en && n == DEPTH)    check("out_valid_full", {31'd0, out_valid}, 1);
        if (!out_valid)          check("out_ctrl_gate", {30'd0, out_ctrl}, 0);
        if (out_valid && out_ready && n > 0) begin
            it = q.pop_front();
            check("out_data", {24'd0, out_data}, {24'd0, it.d});
            check("out_ctrl", {30'd0, out_ctrl}, {30'd0, it.c});
        end
        if (flush) q.delete();
    end

    // One clock: record an input transfer in the scoreboard, then step off the edge
    task automatic tick();
        item_t it;
        @(posedge clk);
        last_acc = in_valid && exp_rdy && !arst;
        if (last_acc) begin
            it.d = in_data;
            it.c = in_ctrl;
            q.push_back(it);
        end
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        tick();
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        en        = 1'b1;
        flush     = 1'b0;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        check("drain_empty", q.size(), 0);
        tick();
        check("drain_out_valid", {31'd0, out_valid}, 0);
    endtask

    initial begin
        arst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; in_ctrl = 2'b00; out_ready = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", {24'd0, out_data}, {24'd0, PRESET});
        check("rst_out_ctrl", {30'd0, out_ctrl}, 0);
        check("rst_occ", {30'd0, occ}, 0);
        tick(); tick();
        arst = 1'b0;
        tick();

        // Streaming latency: first output appears after DEPTH edges
        push(8'h11, 2'b11);
        check("lat_c1", {31'd0, out_valid}, 0);
        push(8'h22, 2'b11);
        check("lat_c2", {31'd0, out_valid}, 0);
        push(8'h33, 2'b11);
        check("lat_c3_valid", {31'd0, out_valid}, 1);
        check("lat_c3_data", {24'd0, out_data}, 32'h11);
        in_valid = 1'b0;
        tick();
        check("lat_c4_data", {24'd0, out_data}, 32'h22);
        tick();
        check("lat_c5_data", {24'd0, out_data}, 32'h33);
        check("lat_c5_ctrl", {30'd0, out_ctrl}, 32'h3);
        tick();
        check("lat_c6_valid", {31'd0, out_valid}, 0);

        // Backpressure: fill, stall, then release with simultaneous transfer
        out_ready = 1'b0;
        push(8'hA0, 2'b01);
        push(8'hA1, 2'b10);
        push(8'hA2, 2'b01);
        in_valid = 1'b1; in_data = 8'hA3; in_ctrl = 2'b11;
        check("bp_ready_low", {31'd0, in_ready}, 0);
`ifdef PIPE_STAGE_OCC_CNT_EN
        check("bp_occ_full", {30'd0, occ}, 3);
`endif
        tick(); tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) break;
        end
        check("bp_a3_accepted", {31'd0, last_acc}, 1);
        drain();

        // Flush with a same-cycle input that must be dropped
        out_ready = 1'b0;
        push(8'h55, 2'b11);
        push(8'h66, 2'b11);
        flush = 1'b1;
        push(8'h77, 2'b11);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 0);
        check("flush_out_ctrl", {30'd0, out_ctrl}, 0);
        check("flush_occ", {30'd0, occ}, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();

        // Global hold mid-stream
        push(8'hB0, 2'b01);
        push(8'hB1, 2'b10);
        en = 1'b0;
        in_valid = 1'b1; in_data = 8'hB2; in_ctrl = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_in_ready", {31'd0, in_ready}, 0);
            check("hold_out_valid", {31'd0, out_valid}, 0);
        end
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) break;
        end
        drain();

        // Asynchronous reset mid-stream
        push(8'hD0, 2'b11);
        push(8'hD1, 2'b11);
        push(8'hD2, 2'b11);
        in_valid = 1'b0;
        #2;
        arst = 1'b1;
        q.delete();
        #1;
        check("arst_out_data", {24'd0, out_data}, {24'd0, PRESET});
        check("arst_out_valid", {31'd0, out_valid}, 0);
        check("arst_out_ctrl", {30'd0, out_ctrl}, 0);
        tick();
        arst = 1'b0;
        push(8'hE0, 2'b01);
        push(8'hE1, 2'b10);
        drain();

        // Bubble collapse: tail full, middle empty, downstream stalled
        out_ready = 1'b0;
        push(8'h99, 2'b01);
        in_valid = 1'b0;
        tick(); tick();
        push(8'hC0, 2'b10);
        check("bubble_ready", {31'd0, in_ready}, 1);
        push(8'hC1, 2'b11);
        check("bubble_full", {31'd0, in_ready}, 0);
        drain();

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_ctrl   = 2'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            en        = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
